word_drain: RTL and testbench

WORD_DRAIN -- requirements
Module: word_drain

---
 rtl/word_drain.sv | 125 ++++++++++++
 tb/tb_word_drain.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_drain.sv
// Drains a 32-bit word buffer into a registered valid/ready output stream and flushes any
// zero-padded partial residue on timeout or request. Define WORD_DRAIN_STATS_EN for word/flush counters.
module word_drain #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] buf_dout,
    input  logic [8:0]  buf_bitsCount,
    input  logic        buf_almost_empty,
    output logic        buf_rden,
    input  logic        flush_req,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [31:0] word_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_PEND, S_FLUSH} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [31:0] data_q;
    logic        valid_q, last_q;
    logic        can_load, has_word, has_bits, load_last;

    assign can_load = ~valid_q | out_ready;
    assign has_word = buf_bitsCount >= 9'd32;
    assign has_bits = buf_bitsCount != 9'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (has_word)      state_d = S_STREAM;
                else if (has_bits) state_d = S_PEND;
            end
            S_STREAM: begin
                if (buf_almost_empty) state_d = has_bits ? S_PEND : S_IDLE;
            end
            S_PEND: begin
                if (has_word)                                  state_d = S_STREAM;
                else if (!has_bits)                            state_d = S_IDLE;
                else if (timer_q == TIMER_LAST || flush_req)   state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // Single read; stay streaming only if a full word is still left behind it.
                if (can_load) state_d = (buf_bitsCount >= 9'd64) ? S_STREAM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        timer_d = timer_q;
        if (state_d == S_PEND && state_q != S_PEND)     timer_d = 8'd0;
        else if (state_q == S_PEND && timer_q != 8'hFF) timer_d = timer_q + 8'd1;
    end

    always_comb begin
        buf_rden  = 1'b0;
        load_last = 1'b0;
        unique case (state_q)
            S_STREAM: buf_rden = can_load & ~buf_almost_empty;
            S_FLUSH: begin
                buf_rden  = can_load & has_bits;
                load_last = ~has_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (buf_rden) begin
            data_q  <= buf_dout;
            valid_q <= 1'b1;
            last_q  <= load_last;
        end else if (out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

`ifdef WORD_DRAIN_STATS_EN
    logic [31:0] wcnt_q;
    logic [15:0] fcnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt_q <= 32'd0;
            fcnt_q <= 16'd0;
        end else if (valid_q && out_ready) begin
            wcnt_q <= wcnt_q + 32'd1;
            if (last_q) fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign word_count  = wcnt_q;
    assign flush_count = fcnt_q;
`else
    assign word_count  = 32'd0;
    assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_word_drain.sv
// Bench for word_drain: a bit-level buffer model feeds the DUT; expected words are the pushed
// bit stream cut into 32-bit MSB-first chunks, with a short tail zero-padded and flagged last.
`timescale 1ns/100ps
module tb_word_drain;
    localparam int TO = 16;
`ifdef WORD_DRAIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] buf_dout;
    logic [8:0]  buf_bitsCount;
    logic        buf_almost_empty;
    logic        buf_rden;
    logic        flush_req = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [31:0] word_count;
    logic [15:0] flush_count;

    always #12.5 clk = ~clk;

    word_drain #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .buf_dout(buf_dout), .buf_bitsCount(buf_bitsCount),
        .buf_almost_empty(buf_almost_empty), .buf_rden(buf_rden), .flush_req(flush_req),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .word_count(word_count), .flush_count(flush_count)
    );

    bit   sbits [0:8191];
    int   push_total = 0;
    int   rd_ptr = 0;
    int   vectors = 0, miscompares = 0;
    int   exp_wc = 0, exp_fc = 0;
    logic [31:0] obs_w[$], exp_w[$], dat_hist[$];
    logic        obs_l[$], exp_l[$], rd_hist[$], val_hist[$], lst_hist[$], rd0_hist[$];

    // Upstream buffer: window of up to 32 unread bits, MSB-first, zero-padded.
    always_comb begin
        int cnt;
        cnt = push_total - rd_ptr;
        buf_bitsCount    = 9'(cnt);
        buf_almost_empty = (cnt < 32);
        buf_dout         = '0;
        for (int i = 0; i < 32; i++)
            if (i < cnt) buf_dout[31-i] = sbits[13'(rd_ptr + i)];
    end

    always @(posedge clk)
        if (buf_rden) rd_ptr <= rd_ptr + (((push_total - rd_ptr) >= 32) ? 32 : (push_total - rd_ptr));

    task automatic push_bits(input int n);
        int base;
        logic [31:0] v;
        base = push_total;
        for (int i = 0; i < n; i++) sbits[13'(base + i)] = 1'($urandom);
        for (int w = 0; w * 32 < n; w++) begin
            v = '0;
            for (int b = 0; b < 32; b++)
                if (w * 32 + b < n) v[31-b] = sbits[13'(base + w * 32 + b)];
            exp_w.push_back(v);
            exp_l.push_back((n - w * 32) < 32);
        end
        push_total = base + n;
    endtask

    task automatic clear_hist();
        rd_hist.delete(); val_hist.delete(); dat_hist.delete(); lst_hist.delete(); rd0_hist.delete();
        obs_w.delete(); obs_l.delete(); exp_w.delete(); exp_l.delete();
    endtask

    // One clock cycle: inputs set by the caller apply to the coming posedge.
    task automatic step();
        #1;
        rd_hist.push_back(buf_rden);
        val_hist.push_back(out_valid);
        dat_hist.push_back(out_data);
        lst_hist.push_back(out_last);
        rd0_hist.push_back(buf_rden && buf_bitsCount == 9'd0);
        if (out_valid && out_ready) begin
            obs_w.push_back(out_data);
            obs_l.push_back(out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        vectors += 6;
        if (out_valid !== 1'b0)    begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (out_last !== 1'b0)     begin miscompares++; $display("FAIL reset_last: got %b want 0", out_last); end
        if (out_data !== 32'd0)    begin miscompares++; $display("FAIL reset_data: got %h want 0", out_data); end
        if (word_count !== 32'd0)  begin miscompares++; $display("FAIL reset_wc: got %0d want 0", word_count); end
        if (flush_count !== 16'd0) begin miscompares++; $display("FAIL reset_fc: got %0d want 0", flush_count); end
        if (buf_rden !== 1'b0)     begin miscompares++; $display("FAIL reset_rden: got %b want 0", buf_rden); end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream96();
        clear_hist();
        push_bits(96);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            flush_req = (c == 0 || c == 2);
            step();
        end
        flush_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (rd_hist[c] !== (c >= 1 && c <= 3)) begin
                miscompares++; $display("FAIL stream96_rden c%0d: got %b want %b", c, rd_hist[c], (c >= 1 && c <= 3));
            end
        end
        vectors++;
        if (obs_w.size() != 3) begin miscompares++; $display("FAIL stream96_nwords: got %0d want 3", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            vectors++;
            if (obs_w[i] !== exp_w[i] || obs_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL stream96_word%0d: got %h/%b want %h/%b", i, obs_w[i], obs_l[i], exp_w[i], exp_l[i]);
            end
        end
        foreach (exp_l[i]) begin exp_wc++; if (exp_l[i]) exp_fc++; end
        vectors += 2;
        if (word_count !== (STATS ? 32'(exp_wc) : 32'd0)) begin miscompares++; $display("FAIL stream96_wc: got %0d want %0d", word_count, STATS ? exp_wc : 0); end
        if (flush_count !== (STATS ? 16'(exp_fc) : 16'd0)) begin miscompares++; $display("FAIL stream96_fc: got %0d want %0d", flush_count, STATS ? exp_fc : 0); end
    endtask

    task automatic test_timeout_flush();
        clear_hist();
        push_bits(40);
        out_ready = 1'b1;
        for (int c = 0; c < TO + 9; c++) step();
        for (int c = 0; c < TO + 9; c++) begin
            vectors++;
            if (rd_hist[c] !== (c == 1 || c == TO + 3)) begin
                miscompares++; $display("FAIL timeout_rden c%0d: got %b want %b", c, rd_hist[c], (c == 1 || c == TO + 3));
            end
        end
        vectors++;
        if (obs_w.size() != 2) begin miscompares++; $display("FAIL timeout_nwords: got %0d want 2", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            vectors++;
            if (obs_w[i] !== exp_w[i] || obs_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL timeout_word%0d: got %h/%b want %h/%b", i, obs_w[i], obs_l[i], exp_w[i], exp_l[i]);
            end
        end
        if (obs_w.size() == 2) begin
            vectors++;
            if ((obs_w[1] & 32'h00FF_FFFF) !== 32'd0) begin
                miscompares++; $display("FAIL timeout_pad: got %h want 000000 in low bits", obs_w[1]);
            end
        end
        foreach (exp_l[i]) begin exp_wc++; if (exp_l[i]) exp_fc++; end
        vectors += 2;
        if (word_count !== (STATS ? 32'(exp_wc) : 32'd0)) begin miscompares++; $display("FAIL timeout_wc: got %0d want %0d", word_count, STATS ? exp_wc : 0); end
        if (flush_count !== (STATS ? 16'(exp_fc) : 16'd0)) begin miscompares++; $display("FAIL timeout_fc: got %0d want %0d", flush_count, STATS ? exp_fc : 0); end
    endtask

    task automatic test_flush_req();
        int k;
        for (int it = 0; it < 2; it++) begin
            k = (it == 0) ? 3 : int'($urandom_range(1, 12));
            clear_hist();
            push_bits(8);
            out_ready = 1'b1;
            for (int c = 0; c < k + 6; c++) begin
                flush_req = (c == k);
                step();
            end
            flush_req = 1'b0;
            for (int c = 0; c < k + 6; c++) begin
                vectors++;
                if (rd_hist[c] !== (c == k + 1)) begin
                    miscompares++; $display("FAIL flushreq_k%0d_rden c%0d: got %b want %b", k, c, rd_hist[c], (c == k + 1));
                end
            end
            vectors++;
            if (obs_w.size() != 1) begin miscompares++; $display("FAIL flushreq_k%0d_nwords: got %0d want 1", k, obs_w.size()); end
            else if (obs_w[0] !== exp_w[0] || obs_l[0] !== 1'b1) begin
                miscompares++; $display("FAIL flushreq_k%0d_word: got %h/%b want %h/1", k, obs_w[0], obs_l[0], exp_w[0]);
            end
            foreach (exp_l[i]) begin exp_wc++; if (exp_l[i]) exp_fc++; end
        end
        vectors++;
        if (flush_count !== (STATS ? 16'(exp_fc) : 16'd0)) begin miscompares++; $display("FAIL flushreq_fc: got %0d want %0d", flush_count, STATS ? exp_fc : 0); end
    endtask

    task automatic test_backpressure();
        int wc0;
        clear_hist();
        push_bits(64);
        wc0 = exp_wc;
        for (int c = 0; c < 9; c++) begin
            out_ready = (c >= 5);
            step();
        end
        for (int c = 0; c < 9; c++) begin
            vectors++;
            if (rd_hist[c] !== (c == 1 || c == 5)) begin
                miscompares++; $display("FAIL bp_rden c%0d: got %b want %b", c, rd_hist[c], (c == 1 || c == 5));
            end
        end
        for (int c = 2; c <= 4; c++) begin
            vectors++;
            if (val_hist[c] !== 1'b1 || dat_hist[c] !== exp_w[0] || lst_hist[c] !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold c%0d: got %b/%h want 1/%h", c, val_hist[c], dat_hist[c], exp_w[0]);
            end
        end
        vectors++;
        if (val_hist[5] !== 1'b1 || val_hist[6] !== 1'b1 || val_hist[7] !== 1'b0) begin
            miscompares++; $display("FAIL bp_b2b: got valid %b%b%b want 110", val_hist[5], val_hist[6], val_hist[7]);
        end
        vectors++;
        if (obs_w.size() != 2) begin miscompares++; $display("FAIL bp_nwords: got %0d want 2", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            vectors++;
            if (obs_w[i] !== exp_w[i] || obs_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL bp_word%0d: got %h/%b want %h/%b", i, obs_w[i], obs_l[i], exp_w[i], exp_l[i]);
            end
        end
        foreach (exp_l[i]) begin exp_wc++; if (exp_l[i]) exp_fc++; end
        vectors++;
        if (word_count !== (STATS ? 32'(wc0 + 2) : 32'd0)) begin miscompares++; $display("FAIL bp_wc: got %0d want %0d", word_count, STATS ? wc0 + 2 : 0); end
    endtask

    task automatic test_random();
        int  n, cyc;
        logic rdy_prev;
        for (int it = 0; it < 6; it++) begin
            clear_hist();
            n = int'($urandom_range(1, 300));
            push_bits(n);
            cyc = 0;
            rdy_prev = 1'b1;
            while (!(obs_w.size() == exp_w.size() && rd_ptr == push_total && !out_valid) && cyc < 3000) begin
                out_ready = ($urandom_range(0, 9) < 7);
                flush_req = ($urandom_range(0, 7) == 0);
                step();
                if (cyc > 0 && val_hist[cyc-1] && !rdy_prev) begin
                    vectors++;
                    if (val_hist[cyc] !== 1'b1 || dat_hist[cyc] !== dat_hist[cyc-1] || lst_hist[cyc] !== lst_hist[cyc-1]) begin
                        miscompares++; $display("FAIL rand%0d_hold c%0d: got %b/%h want 1/%h", it, cyc, val_hist[cyc], dat_hist[cyc], dat_hist[cyc-1]);
                    end
                end
                if (rd0_hist[cyc]) begin
                    vectors++; miscompares++; $display("FAIL rand%0d_rden_empty c%0d: got 1 want 0", it, cyc);
                end
                rdy_prev = out_ready;
                cyc++;
            end
            flush_req = 1'b0;
            vectors++;
            if (cyc >= 3000) begin miscompares++; $display("FAIL rand%0d_timeout: got %0d words want %0d", it, obs_w.size(), exp_w.size()); end
            vectors++;
            if (obs_w.size() != exp_w.size()) begin miscompares++; $display("FAIL rand%0d_nwords: got %0d want %0d", it, obs_w.size(), exp_w.size()); end
            for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
                vectors++;
                if (obs_w[i] !== exp_w[i] || obs_l[i] !== exp_l[i]) begin
                    miscompares++; $display("FAIL rand%0d_word%0d: got %h/%b want %h/%b", it, i, obs_w[i], obs_l[i], exp_w[i], exp_l[i]);
                end
            end
            foreach (exp_l[i]) begin exp_wc++; if (exp_l[i]) exp_fc++; end
            vectors += 2;
            if (word_count !== (STATS ? 32'(exp_wc) : 32'd0)) begin miscompares++; $display("FAIL rand%0d_wc: got %0d want %0d", it, word_count, STATS ? exp_wc : 0); end
            if (flush_count !== (STATS ? 16'(exp_fc) : 16'd0)) begin miscompares++; $display("FAIL rand%0d_fc: got %0d want %0d", it, flush_count, STATS ? exp_fc : 0); end
        end
    endtask

    task automatic test_reset_mid();
        clear_hist();
        push_bits(40);
        out_ready = 1'b0;
        for (int c = 0; c < TO + 6; c++) step();
        vectors++;
        if (val_hist[TO + 5] !== 1'b1 || rd_hist[TO + 5] !== 1'b0) begin
            miscompares++; $display("FAIL rmid_stall: got valid %b rden %b want 1 0", val_hist[TO + 5], rd_hist[TO + 5]);
        end
        rstn = 1'b0;
        #1;
        vectors += 5;
        if (out_valid !== 1'b0)    begin miscompares++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        if (out_last !== 1'b0)     begin miscompares++; $display("FAIL rmid_last: got %b want 0", out_last); end
        if (word_count !== 32'd0)  begin miscompares++; $display("FAIL rmid_wc: got %0d want 0", word_count); end
        if (flush_count !== 16'd0) begin miscompares++; $display("FAIL rmid_fc: got %0d want 0", flush_count); end
        if (buf_rden !== 1'b0)     begin miscompares++; $display("FAIL rmid_rden: got %b want 0", buf_rden); end
        @(negedge clk);
        rstn = 1'b1;
        exp_wc = 0; exp_fc = 0;
        void'(exp_w.pop_front()); void'(exp_l.pop_front());
        rd_hist.delete(); val_hist.delete(); lst_hist.delete(); dat_hist.delete(); rd0_hist.delete();
        obs_w.delete(); obs_l.delete();
        out_ready = 1'b1;
        for (int c = 0; c < TO + 6; c++) step();
        for (int c = 0; c < TO + 6; c++) begin
            vectors++;
            if (rd_hist[c] !== (c == TO + 1)) begin
                miscompares++; $display("FAIL rmid_rden c%0d: got %b want %b", c, rd_hist[c], (c == TO + 1));
            end
        end
        vectors++;
        if (lst_hist[0] !== 1'b0 || lst_hist[1] !== 1'b0) begin miscompares++; $display("FAIL rmid_spurious_last: got %b%b want 00", lst_hist[0], lst_hist[1]); end
        vectors++;
        if (obs_w.size() != 1) begin miscompares++; $display("FAIL rmid_nwords: got %0d want 1", obs_w.size()); end
        else if (obs_w[0] !== exp_w[0] || obs_l[0] !== exp_l[0]) begin
            miscompares++; $display("FAIL rmid_word: got %h/%b want %h/%b", obs_w[0], obs_l[0], exp_w[0], exp_l[0]);
        end
        foreach (exp_l[i]) begin exp_wc++; if (exp_l[i]) exp_fc++; end
        vectors += 2;
        if (word_count !== (STATS ? 32'(exp_wc) : 32'd0)) begin miscompares++; $display("FAIL rmid_wc_after: got %0d want %0d", word_count, STATS ? exp_wc : 0); end
        if (flush_count !== (STATS ? 16'(exp_fc) : 16'd0)) begin miscompares++; $display("FAIL rmid_fc_after: got %0d want %0d", flush_count, STATS ? exp_fc : 0); end
    endtask

    initial begin
        test_reset();
        test_stream96();
        test_timeout_flush();
        test_flush_req();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
